// File: rtl/bcd_encryptor.sv
// BCD digit-cipher encryptor: encodes digits 0-9 into 4-bit cipher codes, buffers them in a
// DEPTH-entry FIFO and drops/counts non-BCD input. Optional macro ENC_PARITY_EN adds out_parity.
module bcd_encryptor #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_digit,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_code,
   output logic                     err_pulse,
   output logic [7:0]               err_count,
   output logic [$clog2(DEPTH):0]   level
`ifdef ENC_PARITY_EN
   ,
   output logic                     out_parity
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
`ifdef ENC_PARITY_EN
   localparam int MW = 5;
`else
   localparam int MW = 4;
`endif
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [MW-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          err_pulse_q, err_pulse_d;
   logic [7:0]    err_count_q, err_count_d;

   logic          accept, is_bcd, push, pop, drop;
   logic [3:0]    enc_code;
   logic [MW-1:0] wr_word;
   logic [MW-1:0] rd_word;

   function automatic logic [3:0] encode(input logic [3:0] d);
      logic [3:0] c;
      case (d)
         4'd0:    c = 4'b1101;
         4'd1:    c = 4'b1100;
         4'd2:    c = 4'b1011;
         4'd3:    c = 4'b1010;
         4'd4:    c = 4'b1001;
         4'd5:    c = 4'b1000;
         4'd6:    c = 4'b0011;
         4'd7:    c = 4'b0000;
         4'd8:    c = 4'b0101;
         4'd9:    c = 4'b0110;
         default: c = 4'b0000;
      endcase
      return c;
   endfunction

   // in_ready depends only on occupancy, never on out_ready
   assign in_ready  = (level_q < FULL_LEVEL);
   assign out_valid = (level_q != '0);
   assign level     = level_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

   always_comb begin
      accept   = in_valid & in_ready;
      is_bcd   = (in_digit <= 4'd9);
      push     = accept & is_bcd;
      drop     = accept & ~is_bcd;
      pop      = out_valid & out_ready;
      enc_code = encode(in_digit);
`ifdef ENC_PARITY_EN
      wr_word  = {~^enc_code, enc_code};
`else
      wr_word  = enc_code;
`endif
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      err_pulse_d = drop;
      err_count_d = err_count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!push && pop) begin
         level_d = level_q - LW'(1);
      end
      if (drop && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   // Storage carries no reset; an empty FIFO masks its contents at the output
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_word;
      end
   end

   assign rd_word  = mem_q[rd_ptr_q];
   assign out_code = out_valid ? rd_word[3:0] : 4'b0000;
`ifdef ENC_PARITY_EN
   assign out_parity = out_valid ? rd_word[4] : 1'b1;
`endif

endmodule
